read_ptr_ctrl_fwft: RTL and testbench
=====================================

// Module: read_ptr_ctrl_fwft
// PURPOSE
//  Read-domain pointer/flag controller for the async FIFO. Parametrised successor of the
//  basic read pointer block: registered empty, occupancy count, almost-empty, underflow
//  pulse, memory read-enable, and optional first-word-fall-through (FWFT) mode.
//  Sits between the write-pointer 2-flop synchroniser and the sync-read dual-port RAM.
// PARAMETERS
//  ADDR_W    3  RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits
//  AE_LEVEL  1  ralmost_empty asserts when rcount <= AE_LEVEL
//  FWFT      0  0 = standard (data 1 cycle after read); 1 = first-word-fall-through
// PORTS
//  rclk          in   1         read clock
//  rrst          in   1         reset; asynchronous, active-high
//  sync_wptr     in   ADDR_W+1  Gray write pointer, already synchronised into rclk
//  rinc          in   1         read request / pop
//  raddr         out  ADDR_W    RAM read address
//  rptr          out  ADDR_W+1  Gray read pointer, to the write-domain synchroniser
//  mem_ren       out  1         RAM read enable (sync-read RAM, 1-cycle latency, holds dout)
//  rempty        out  1         FIFO empty as seen by the consumer
//  rvalid        out  1         RAM dout holds valid read data this cycle
//  ralmost_empty out  1         rcount <= AE_LEVEL
//  rcount        out  ADDR_W+1  words available to the consumer
//  runderflow    out  1         1-cycle pulse: rinc was asserted while rempty
// BEHAVIOUR
//  Reset (rrst=1, async, immediate): rptr_bin=0, raddr=0, rptr=0, rempty=1, rvalid=0,
//   rcount=0, ralmost_empty=1, runderflow=0, mem_ren=0. In-flight read is discarded.
//  Internal: rptr_bin (ADDR_W+1, registered); empty_int registered.
//   fetch = mem_ren; rbin_next = rptr_bin + fetch (mod 2**(ADDR_W+1)).
//   empty_int <= (bin2gray(rbin_next) == sync_wptr); raddr = rptr_bin[ADDR_W-1:0];
//   rptr = bin2gray(rptr_bin), registered with rptr_bin (no glitch into other domain).
//  FWFT=0:
//   mem_ren = rinc & ~empty_int; rempty = empty_int; rvalid <= mem_ren (data 1 cycle later).
//  FWFT=1 (RAM dout register is the output stage):
//   mem_ren = ~empty_int & (~rvalid | rinc); rvalid <= mem_ren | (rvalid & ~rinc);
//   rempty = ~rvalid. First word appears without rinc: sync_wptr change -> empty_int
//   falls next edge -> mem_ren -> rvalid=1 one edge later. rinc with rvalid pops the
//   word; next word follows back-to-back if available, else rvalid drops.
//  rcount registered: (gray2bin(sync_wptr) - rbin_next) mod 2**(ADDR_W+1),
//   plus rvalid_next when FWFT=1. Range 0..2**ADDR_W (+1 in FWFT). 1-cycle latency.
//  ralmost_empty = (rcount <= AE_LEVEL), from registered rcount.
//  Underflow: rinc & rempty -> no pointer/raddr change, runderflow=1 on the next cycle only.
//  Wrap: rptr_bin rolls 2**(ADDR_W+1)-1 -> 0; MSB toggles each pass; raddr wraps at depth.
//  Simultaneous sync_wptr advance and last read: empty_int uses rbin_next, so rempty
//   deasserts/stays deasserted correctly; no lost or duplicated words.
//  sync_wptr is Gray-coded and moves by <=1 code per rclk; it never passes rptr by
//   more than 2**ADDR_W (write side guarantees no overflow).
// TESTING (ADDR_W=3)
//  T1 reset: assert rrst mid-stream with rvalid=1 -> same cycle rempty=1, rvalid=0,
//     rptr=4'b0000, rcount=0, ralmost_empty=1; hold after release until sync_wptr moves.
//  T2 FWFT=0: sync_wptr=gray(3)=4'b0010 -> rempty=0 next edge, rcount=3; rinc x3 ->
//     mem_ren on raddr 0,1,2, rvalid one cycle after each; rempty=1 after third, rptr=4'b0010.
//  T3 wrap: 16 writes/reads in batches of 8 -> rptr_bin 15->0, rptr 4'b1000->4'b0000,
//     raddr 7->0, rempty=1 at each batch end, rcount never exceeds 8.
//  T4 underflow: rinc=1 for 2 cycles while empty -> rptr/raddr unchanged, mem_ren=0,
//     runderflow high exactly 2 cycles, each one cycle after its rinc.
//  T5 almost-empty, AE_LEVEL=2: rcount=3 -> ralmost_empty=0; one read -> rcount=2,
//     ralmost_empty=1 on the following cycle.
//  T6 FWFT=1: sync_wptr=gray(2), rinc=0 -> mem_ren on raddr 0, rvalid=1 and rempty=0
//     next cycle; rinc held 2 cycles -> word 1 back-to-back, then rvalid=0, rempty=1.

Source files
------------

// File: rtl/read_ptr_ctrl_fwft.sv
// Read-domain pointer and flag controller for the async FIFO.
// Keeps the binary/Gray read pointers, a registered empty flag, the occupancy
// count, almost-empty and underflow flags, and drives the sync-read RAM.
// With FWFT=1 the RAM output register acts as a one-word output stage.
module read_ptr_ctrl_fwft #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   sync_wptr,
  input  logic              rinc,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr,
  output logic              mem_ren,
  output logic              rempty,
  output logic              rvalid,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rcount,
  output logic              runderflow
);

  localparam int unsigned     PW     = ADDR_W + 1;
  localparam logic [ADDR_W:0] AE_THR = PW'(AE_LEVEL);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int unsigned i = ADDR_W; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  logic [ADDR_W:0] rptr_bin_q, rptr_bin_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic            empty_q, empty_d;
  logic            rvalid_q, rvalid_d;
  logic [ADDR_W:0] rcount_q, rcount_d;
  logic            runderflow_q, runderflow_d;

  // Read enable, consumer-facing empty, and next-state of pointers and flags.
  // Empty and count look at the post-fetch pointer so a read coinciding with
  // a write-pointer advance neither loses nor repeats a word.
  always_comb begin
    mem_ren  = 1'b0;
    rvalid_d = 1'b0;
    rempty   = empty_q;
    if (FWFT != 0) begin
      // Output stage refills whenever it is empty or being popped.
      mem_ren  = ~empty_q & (~rvalid_q | rinc);
      rvalid_d = mem_ren | (rvalid_q & ~rinc);
      rempty   = ~rvalid_q;
    end else begin
      mem_ren  = rinc & ~empty_q;
      rvalid_d = mem_ren;
      rempty   = empty_q;
    end
    rptr_bin_d   = rptr_bin_q + {{ADDR_W{1'b0}}, mem_ren};
    rptr_d       = bin2gray(rptr_bin_d);
    empty_d      = (rptr_d == sync_wptr);
    rcount_d     = gray2bin(sync_wptr) - rptr_bin_d;
    if (FWFT != 0) begin
      rcount_d = rcount_d + {{ADDR_W{1'b0}}, rvalid_d};
    end
    runderflow_d = rinc & rempty;
  end

  // State registers; reset discards any in-flight read.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rptr_bin_q   <= '0;
      rptr_q       <= '0;
      empty_q      <= 1'b1;
      rvalid_q     <= 1'b0;
      rcount_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rptr_bin_q   <= rptr_bin_d;
      rptr_q       <= rptr_d;
      empty_q      <= empty_d;
      rvalid_q     <= rvalid_d;
      rcount_q     <= rcount_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr         = rptr_bin_q[ADDR_W-1:0];
  assign rptr          = rptr_q;
  assign rvalid        = rvalid_q;
  assign rcount        = rcount_q;
  assign ralmost_empty = (rcount_q <= AE_THR);
  assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_read_ptr_ctrl_fwft.sv
// Randomized bench for read_ptr_ctrl_fwft: one standard instance (AE_LEVEL=2)
// and one FWFT instance (AE_LEVEL=1), checked against a word-count model.
module tb_read_ptr_ctrl_fwft;

  logic       clk;
  logic       rrst;
  logic [3:0] sync_wptr [2];
  logic       rinc      [2];
  logic [2:0] raddr     [2];
  logic [3:0] rptr      [2];
  logic       mem_ren   [2];
  logic       rempty    [2];
  logic       rvalid    [2];
  logic       ralm      [2];
  logic [3:0] rcount    [2];
  logic       runder    [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: words written (driven), words visible at last edge, words fetched,
  // FWFT output-stage occupancy, pending underflow pulse.
  int unsigned w  [2];
  int unsigned ws [2];
  int unsigned f  [2];
  bit          vld[2];
  bit          uf [2];
  int unsigned ae_lvl [2];

  read_ptr_ctrl_fwft #(.ADDR_W(3), .AE_LEVEL(2), .FWFT(0)) u0 (
    .rclk(clk), .rrst(rrst), .sync_wptr(sync_wptr[0]), .rinc(rinc[0]),
    .raddr(raddr[0]), .rptr(rptr[0]), .mem_ren(mem_ren[0]), .rempty(rempty[0]),
    .rvalid(rvalid[0]), .ralmost_empty(ralm[0]), .rcount(rcount[0]),
    .runderflow(runder[0])
  );

  read_ptr_ctrl_fwft #(.ADDR_W(3), .AE_LEVEL(1), .FWFT(1)) u1 (
    .rclk(clk), .rrst(rrst), .sync_wptr(sync_wptr[1]), .rinc(rinc[1]),
    .raddr(raddr[1]), .rptr(rptr[1]), .mem_ren(mem_ren[1]), .rempty(rempty[1]),
    .rvalid(rvalid[1]), .ralmost_empty(ralm[1]), .rcount(rcount[1]),
    .runderflow(runder[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned gray4(input int unsigned b);
    int unsigned m;
    m = b % 16;
    return m ^ (m >> 1);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      w[d] = 0; ws[d] = 0; f[d] = 0; vld[d] = 0; uf[d] = 0;
      sync_wptr[d] = '0;
      rinc[d] = 1'b0;
    end
  endtask

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("u%0d.rst.rempty", d),  rempty[d],  1);
      check_eq($sformatf("u%0d.rst.rvalid", d),  rvalid[d],  0);
      check_eq($sformatf("u%0d.rst.rptr", d),    rptr[d],    0);
      check_eq($sformatf("u%0d.rst.raddr", d),   raddr[d],   0);
      check_eq($sformatf("u%0d.rst.rcount", d),  rcount[d],  0);
      check_eq($sformatf("u%0d.rst.ralm", d),    ralm[d],    1);
      check_eq($sformatf("u%0d.rst.runder", d),  runder[d],  0);
      check_eq($sformatf("u%0d.rst.mem_ren", d), mem_ren[d], 0);
    end
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance the model
  // to what the coming posedge should produce.
  task automatic step(input int unsigned pw, input int unsigned pr);
    int unsigned avail, exp_cnt;
    bit          e_empty, e_ren, popped;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      // Write side never runs more than a full RAM ahead of the fetch pointer.
      if ($urandom_range(99) < pw && (w[d] + 1 - f[d]) <= 8) w[d]++;
      sync_wptr[d] = 4'(gray4(w[d]));
      rinc[d]      = ($urandom_range(99) < pr);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      avail = ws[d] - f[d];
      if (d == 0) begin
        e_empty = (avail == 0);
        e_ren   = rinc[d] && (avail != 0);
        exp_cnt = avail;
      end else begin
        e_empty = !vld[d];
        popped  = rinc[d] && vld[d];
        e_ren   = (avail != 0) && (!vld[d] || popped);
        exp_cnt = avail + (vld[d] ? 1 : 0);
      end
      check_eq($sformatf("u%0d.rempty", d),  rempty[d],  e_empty);
      check_eq($sformatf("u%0d.rvalid", d),  rvalid[d],  vld[d]);
      check_eq($sformatf("u%0d.mem_ren", d), mem_ren[d], e_ren);
      check_eq($sformatf("u%0d.raddr", d),   raddr[d],   f[d] % 8);
      check_eq($sformatf("u%0d.rptr", d),    rptr[d],    gray4(f[d]));
      check_eq($sformatf("u%0d.rcount", d),  rcount[d],  exp_cnt);
      check_eq($sformatf("u%0d.ralm", d),    ralm[d],    exp_cnt <= ae_lvl[d]);
      check_eq($sformatf("u%0d.runder", d),  runder[d],  uf[d]);
      uf[d] = rinc[d] && e_empty;
      if (d == 0) vld[d] = e_ren;
      else        vld[d] = e_ren || (vld[d] && !rinc[d]);
      if (e_ren) f[d]++;
      ws[d] = w[d];
    end
  endtask

  // Asynchronous reset landing between clock edges, checked before any edge.
  task automatic async_reset();
    #2;
    rrst = 1'b1;
    model_clear();
    #1;
    check_reset();
    @(negedge clk);
    rrst = 1'b0;
  endtask

  initial begin
    ae_lvl[0] = 2;
    ae_lvl[1] = 1;
    rrst = 1'b1;
    model_clear();
    #1;
    check_reset();
    @(negedge clk);
    rrst = 1'b0;

    for (int i = 0; i < 60; i++)  step(0, 0);     // idle after reset
    for (int i = 0; i < 40; i++)  step(0, 100);   // underflow on empty
    for (int i = 0; i < 300; i++) step(80, 30);   // fill towards full
    for (int i = 0; i < 300; i++) step(25, 80);   // drain, underflow
    for (int i = 0; i < 400; i++) begin
      step(60, 60);
      if (i >= 50 && (vld[1] || i == 399)) begin
        async_reset();
        break;
      end
    end
    for (int i = 0; i < 10; i++)  step(0, 0);     // held empty after release
    for (int i = 0; i < 600; i++) step(90, 90);   // streaming with wraps
    for (int i = 0; i < 400; i++) step(50, 50);
    for (int i = 0; i < 60; i++)  step(0, 100);   // final drain

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
